// File: rtl/if_fetch_queue.sv
// ---------------------------------------------------------------------------
// if_fetch_queue
//
// Purpose:
//   Instruction-fetch front end. It owns the fetch PC and issues in-order
//   requests to instruction memory over a valid/ready channel. In-order
//   responses are paired with their PC and stored in a QUEUE_DEPTH-entry
//   prefetch queue, which feeds decode through a valid/ready handshake.
//   A branch redirect reloads the PC, flushes the queue and discards any
//   responses still in flight for the old path.
//
// Handshakes:
//   A transfer happens on a rising clk edge where valid & ready are both 1.
//   The producer holds valid and its payload stable until that edge. The
//   only exception is redirect, which may withdraw imem_req_valid and
//   out_valid in any cycle. imem_rsp_valid has no ready and is always taken.
//
// Ports:
//   clk                                  clock, rising edge
//   rst                                  asynchronous, active-low reset
//   redirect / redirect_pc               branch taken, new fetch target
//   imem_req_valid/ready/addr            request channel to instruction memory
//   imem_rsp_valid/data                  in-order response, no backpressure
//   out_valid/ready                      queue head handshake to decode
//   out_pc/out_pc_next/out_instr         queue head payload
//   perf_stall_cnt / perf_flush_cnt      present only with IF_PERF_CNT_EN
//
// Configuration:
//   IF_PERF_CNT_EN  when defined, adds saturating 32-bit stall and flush
//                   counters.
// ---------------------------------------------------------------------------
module if_fetch_queue #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned PC_STEP     = 4,
    parameter int unsigned QUEUE_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [ADDR_W-1:0] out_pc_next,
    output logic [DATA_W-1:0] out_instr
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_flush_cnt
`endif
);

    localparam int unsigned PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [ADDR_W-1:0] LP_STEP = ADDR_W'(PC_STEP);

    logic [ADDR_W-1:0] r_fetch_pc;
    logic [CW-1:0]     r_count;
    logic [CW-1:0]     r_inflight;
    logic [CW-1:0]     r_discard;

    // Prefetch queue storage and pointers.
    logic [ADDR_W-1:0] r_q_pc    [QUEUE_DEPTH];
    logic [DATA_W-1:0] r_q_instr [QUEUE_DEPTH];
    logic [PW-1:0]     r_q_rptr;
    logic [PW-1:0]     r_q_wptr;

    // PC tag FIFO: one entry per live (non-discarded) outstanding request.
    logic [ADDR_W-1:0] r_tag     [QUEUE_DEPTH];
    logic [PW-1:0]     r_tag_rptr;
    logic [PW-1:0]     r_tag_wptr;

    logic [CW:0]       w_used;
    logic              w_credit;
    logic              w_req_valid;
    logic              w_req_fire;
    logic              w_head_valid;
    logic              w_pop;
    logic              w_rsp_drop;
    logic              w_push;
    logic [ADDR_W-1:0] w_head_pc;

    // Queued entries plus outstanding requests may never exceed the queue
    // size, so every response is guaranteed a free slot on arrival.
    assign w_used       = {1'b0, r_count} + {1'b0, r_inflight};
    assign w_credit     = (w_used < (CW+1)'(QUEUE_DEPTH));
    assign w_req_valid  = w_credit & ~redirect;
    assign w_req_fire   = w_req_valid & imem_req_ready;
    assign w_head_valid = (r_count != '0);
    assign w_pop        = w_head_valid & ~redirect & out_ready;
    assign w_rsp_drop   = imem_rsp_valid & (r_discard != '0);
    assign w_push       = imem_rsp_valid & (r_discard == '0) & ~redirect;
    assign w_head_pc    = r_q_pc[r_q_rptr];

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_fetch_pc;
    assign out_valid      = w_head_valid & ~redirect;
    // Head payload reads as zero while the queue is empty.
    assign out_pc         = w_head_valid ? w_head_pc : '0;
    assign out_pc_next    = w_head_valid ? (w_head_pc + LP_STEP) : '0;
    assign out_instr      = w_head_valid ? r_q_instr[r_q_rptr] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc <= RESET_PC;
            r_count    <= '0;
            r_inflight <= '0;
            r_discard  <= '0;
            r_q_rptr   <= '0;
            r_q_wptr   <= '0;
            r_tag_rptr <= '0;
            r_tag_wptr <= '0;
        end else if (redirect) begin
            r_fetch_pc <= redirect_pc;
            r_count    <= '0;
            r_q_rptr   <= '0;
            r_q_wptr   <= '0;
            r_tag_rptr <= '0;
            r_tag_wptr <= '0;
            // Everything still outstanding after this edge is for the old
            // path. A response arriving this cycle is already dropped.
            r_inflight <= r_inflight - CW'(imem_rsp_valid);
            r_discard  <= r_inflight - CW'(imem_rsp_valid);
        end else begin
            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + LP_STEP;
                r_tag_wptr <= r_tag_wptr + 1'b1;
            end
            if (w_push) begin
                r_q_wptr   <= r_q_wptr + 1'b1;
                r_tag_rptr <= r_tag_rptr + 1'b1;
            end
            if (w_pop) begin
                r_q_rptr <= r_q_rptr + 1'b1;
            end
            if (w_rsp_drop) begin
                r_discard <= r_discard - 1'b1;
            end
            r_count    <= r_count + CW'(w_push) - CW'(w_pop);
            r_inflight <= r_inflight + CW'(w_req_fire) - CW'(imem_rsp_valid);
        end
    end

    // Storage arrays need no reset: the counters and pointers decide what
    // is valid, and the head outputs are zeroed while empty.
    always_ff @(posedge clk) begin
        if (w_req_fire) begin
            r_tag[r_tag_wptr] <= r_fetch_pc;
        end
        if (w_push) begin
            r_q_pc[r_q_wptr]    <= r_tag[r_tag_rptr];
            r_q_instr[r_q_wptr] <= imem_rsp_data;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;
    logic        w_flush_drops;

    // A redirect costs work only when the queue holds entries or
    // live (not already discarded) requests are outstanding.
    assign w_flush_drops = redirect & (w_head_valid | (r_inflight != r_discard));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!w_head_valid && !redirect && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush_drops && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign perf_stall_cnt = r_stall_cnt;
    assign perf_flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_pc_next;
  logic [31:0] out_instr;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
  logic [31:0] o_stall;
  logic [31:0] o_flush;
`endif

  int total = 0;
  int bad   = 0;

  // memory model state
  logic [31:0] pend_addr_q[$];
  int          pend_due_q[$];
  int          mem_lat = 1;
  int          cyc     = 0;
  int          n_acc   = 0;

  // observations of the last step
  logic        o_rv;
  logic [31:0] o_ra;
  logic        o_ov;
  logic [31:0] o_pc;
  logic [31:0] o_pn;
  logic [31:0] o_in;

  if_fetch_queue #(
    .ADDR_W(32), .DATA_W(32), .RESET_PC(32'h100), .PC_STEP(4), .QUEUE_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_pc_next(out_pc_next), .out_instr(out_instr)
`ifdef IF_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'd3) ^ 32'hDEAD_0000;
  endfunction

  // one clock cycle: drive at negedge, sample 1 ns later, record accepts
  task automatic step(input logic redir, input logic [31:0] rpc,
                      input logic mrdy, input logic ordy);
    @(negedge clk);
    redirect       = redir;
    redirect_pc    = rpc;
    imem_req_ready = mrdy;
    out_ready      = ordy;
    if (pend_due_q.size() > 0 && pend_due_q[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_data(pend_addr_q[0]);
      void'(pend_addr_q.pop_front());
      void'(pend_due_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
    o_rv = imem_req_valid;
    o_ra = imem_req_addr;
    o_ov = out_valid;
    o_pc = out_pc;
    o_pn = out_pc_next;
    o_in = out_instr;
`ifdef IF_PERF_CNT_EN
    o_stall = perf_stall_cnt;
    o_flush = perf_flush_cnt;
`endif
    if (imem_req_valid && imem_req_ready) begin
      pend_addr_q.push_back(imem_req_addr);
      pend_due_q.push_back(cyc + mem_lat);
      n_acc++;
    end
    cyc++;
  endtask

  // redirect to x and let every outstanding response drain, leaving the
  // DUT idle with fetch_pc = x
  task automatic settle(input logic [31:0] x);
    step(1'b1, x, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      if (pend_due_q.size() == 0) break;
      step(1'b0, '0, 1'b0, 1'b1);
    end
    total++;
    if (pend_due_q.size() != 0) begin
      bad++;
      $display("FAIL settle_drain: pending=%0d want 0", pend_due_q.size());
    end
    step(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b0; redirect = 1'b1; redirect_pc = 32'hDEAD_0000;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
    total++; if (imem_req_addr !== 32'h100) begin bad++; $display("FAIL rst_req_addr: got %h want 00000100", imem_req_addr); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL rst_out_pc: got %h want 0", out_pc); end
    total++; if (out_pc_next !== 32'h0) begin bad++; $display("FAIL rst_out_pc_next: got %h want 0", out_pc_next); end
    total++; if (out_instr !== 32'h0) begin bad++; $display("FAIL rst_out_instr: got %h want 0", out_instr); end
`ifdef IF_PERF_CNT_EN
    total++; if (perf_stall_cnt !== 32'h0) begin bad++; $display("FAIL rst_stall_cnt: got %0d want 0", perf_stall_cnt); end
    total++; if (perf_flush_cnt !== 32'h0) begin bad++; $display("FAIL rst_flush_cnt: got %0d want 0", perf_flush_cnt); end
`endif
    redirect = 1'b0;
    rst = 1'b1;
  endtask

  // plan 1: streaming from RESET_PC, out_pc two cycles behind
  task automatic test_stream();
    logic [31:0] ea;
    logic [31:0] ep;
    mem_lat = 1;
    for (int k = 0; k < 8; k++) begin
      step(1'b0, '0, 1'b1, 1'b1);
      ea = 32'h100 + 32'(4 * k);
      total++; if (o_rv !== 1'b1 || o_ra !== ea) begin bad++; $display("FAIL stream_req k=%0d: got v=%b a=%h want v=1 a=%h", k, o_rv, o_ra, ea); end
      if (k >= 2) begin
        ep = 32'h100 + 32'(4 * (k - 2));
        total++; if (o_ov !== 1'b1 || o_pc !== ep) begin bad++; $display("FAIL stream_out k=%0d: got v=%b pc=%h want v=1 pc=%h", k, o_ov, o_pc, ep); end
        total++; if (o_pn !== ep + 32'd4) begin bad++; $display("FAIL stream_pc_next k=%0d: got %h want %h", k, o_pn, ep + 32'd4); end
        total++; if (o_in !== mem_data(ep)) begin bad++; $display("FAIL stream_instr k=%0d: got %h want %h", k, o_in, mem_data(ep)); end
      end else begin
        total++; if (o_ov !== 1'b0) begin bad++; $display("FAIL stream_early_valid k=%0d: got %b want 0", k, o_ov); end
      end
    end
  endtask

  // plan 2: decode stalled, credit caps requests at 4, then drain in order
  task automatic test_backpressure();
    int acc0;
    settle(32'h0);
    mem_lat = 1;
    acc0 = n_acc;
    for (int k = 0; k < 8; k++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      if (k < 4) begin
        total++; if (o_rv !== 1'b1 || o_ra !== 32'(4 * k)) begin bad++; $display("FAIL bp_req k=%0d: got v=%b a=%h want v=1 a=%h", k, o_rv, o_ra, 32'(4 * k)); end
      end else begin
        total++; if (o_rv !== 1'b0) begin bad++; $display("FAIL bp_credit k=%0d: got v=%b want 0", k, o_rv); end
      end
      if (k >= 2) begin
        total++; if (o_ov !== 1'b1 || o_pc !== 32'h0) begin bad++; $display("FAIL bp_hold k=%0d: got v=%b pc=%h want v=1 pc=0", k, o_ov, o_pc); end
      end
    end
    total++; if (n_acc - acc0 != 4) begin bad++; $display("FAIL bp_req_count: got %0d want 4", n_acc - acc0); end
    for (int k = 0; k < 4; k++) begin
      step(1'b0, '0, 1'b1, 1'b1);
      total++; if (o_ov !== 1'b1 || o_pc !== 32'(4 * k)) begin bad++; $display("FAIL bp_drain k=%0d: got v=%b pc=%h want v=1 pc=%h", k, o_ov, o_pc, 32'(4 * k)); end
      if (k == 0) begin
        total++; if (o_rv !== 1'b0) begin bad++; $display("FAIL bp_full_at_pop: got v=%b want 0", o_rv); end
      end
      if (k == 1) begin
        total++; if (o_rv !== 1'b1 || o_ra !== 32'h10) begin bad++; $display("FAIL bp_resume: got v=%b a=%h want v=1 a=00000010", o_rv, o_ra); end
      end
    end
  endtask

  // plan 3: latency 3, three stale requests in flight at redirect
  task automatic test_redirect_latency();
    settle(32'h600);
    mem_lat = 3;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, '0, 1'b1, 1'b1);
      total++; if (o_ra !== 32'h600 + 32'(4 * k)) begin bad++; $display("FAIL rl_req k=%0d: got %h want %h", k, o_ra, 32'h600 + 32'(4 * k)); end
    end
    step(1'b1, 32'h2000, 1'b1, 1'b1);
    total++; if (o_rv !== 1'b0 || o_ov !== 1'b0) begin bad++; $display("FAIL rl_redirect_gate: got req_v=%b out_v=%b want 0 0", o_rv, o_ov); end
    for (int k = 0; k < 6; k++) begin
      step(1'b0, '0, 1'b1, 1'b1);
      if (k == 0) begin
        total++; if (o_rv !== 1'b1 || o_ra !== 32'h2000) begin bad++; $display("FAIL rl_new_req: got v=%b a=%h want v=1 a=00002000", o_rv, o_ra); end
      end
      if (k < 4) begin
        total++; if (o_ov !== 1'b0) begin bad++; $display("FAIL rl_stale_leak k=%0d: got v=%b pc=%h want v=0", k, o_ov, o_pc); end
      end else begin
        total++; if (o_ov !== 1'b1 || o_pc !== 32'h2000 + 32'(4 * (k - 4))) begin bad++; $display("FAIL rl_first_out k=%0d: got v=%b pc=%h want v=1 pc=%h", k, o_ov, o_pc, 32'h2000 + 32'(4 * (k - 4))); end
        total++; if (o_in !== mem_data(32'h2000 + 32'(4 * (k - 4)))) begin bad++; $display("FAIL rl_instr k=%0d: got %h want %h", k, o_in, mem_data(32'h2000 + 32'(4 * (k - 4)))); end
      end
    end
  endtask

  // plan 4: redirect in the same cycle as a response with two in flight
  task automatic test_redirect_same_rsp();
    settle(32'h700);
    mem_lat = 2;
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b1, 32'h3000, 1'b0, 1'b1);
    total++; if (imem_rsp_valid !== 1'b1) begin bad++; $display("FAIL sr_setup_rsp: got %b want 1", imem_rsp_valid); end
    total++; if (o_rv !== 1'b0 || o_ov !== 1'b0) begin bad++; $display("FAIL sr_redirect_gate: got req_v=%b out_v=%b want 0 0", o_rv, o_ov); end
    step(1'b0, '0, 1'b0, 1'b1);
    total++; if (o_ov !== 1'b0) begin bad++; $display("FAIL sr_leak_c3: got v=%b pc=%h want v=0", o_ov, o_pc); end
    for (int k = 0; k < 4; k++) begin
      step(1'b0, '0, 1'b1, 1'b1);
      if (k == 0) begin
        total++; if (o_rv !== 1'b1 || o_ra !== 32'h3000) begin bad++; $display("FAIL sr_new_req: got v=%b a=%h want v=1 a=00003000", o_rv, o_ra); end
      end
      if (k < 3) begin
        total++; if (o_ov !== 1'b0) begin bad++; $display("FAIL sr_empty k=%0d: got v=%b pc=%h want v=0", k, o_ov, o_pc); end
      end else begin
        total++; if (o_ov !== 1'b1 || o_pc !== 32'h3000) begin bad++; $display("FAIL sr_first_out: got v=%b pc=%h want v=1 pc=00003000", o_ov, o_pc); end
      end
    end
  endtask

  // plan 5: PC wraps modulo 2^32
  task automatic test_wrap();
    logic [31:0] base;
    logic [31:0] ea;
    logic [31:0] ep;
    settle(32'hFFFF_FFF8);
    mem_lat = 1;
    base = 32'hFFFF_FFF8;
    for (int k = 0; k < 4; k++) begin
      step(1'b0, '0, 1'b1, 1'b1);
      ea = base + 32'(4 * k);
      total++; if (o_ra !== ea) begin bad++; $display("FAIL wrap_req k=%0d: got %h want %h", k, o_ra, ea); end
      if (k >= 2) begin
        ep = base + 32'(4 * (k - 2));
        total++; if (o_pc !== ep || o_pn !== ep + 32'd4) begin bad++; $display("FAIL wrap_out k=%0d: got pc=%h nx=%h want pc=%h nx=%h", k, o_pc, o_pn, ep, ep + 32'd4); end
      end
    end
    total++; if (o_pn !== 32'h0) begin bad++; $display("FAIL wrap_pc_next_zero: got %h want 00000000", o_pn); end
  endtask

  // plan 6: redirect with two queued entries, then empty cycles
  task automatic test_flush_queued();
`ifdef IF_PERF_CNT_EN
    logic [31:0] s0;
    logic [31:0] f0;
`endif
    settle(32'h400);
    mem_lat = 1;
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    total++; if (o_ov !== 1'b1 || o_pc !== 32'h400) begin bad++; $display("FAIL fq_queued: got v=%b pc=%h want v=1 pc=00000400", o_ov, o_pc); end
    step(1'b1, 32'h800, 1'b0, 1'b1);
    total++; if (o_ov !== 1'b0 || o_rv !== 1'b0) begin bad++; $display("FAIL fq_gate: got out_v=%b req_v=%b want 0 0", o_ov, o_rv); end
`ifdef IF_PERF_CNT_EN
    s0 = o_stall;
    f0 = o_flush;
`endif
    for (int k = 0; k < 3; k++) begin
      step(1'b0, '0, 1'b0, 1'b1);
      total++; if (o_ov !== 1'b0) begin bad++; $display("FAIL fq_cleared k=%0d: got v=%b pc=%h want v=0", k, o_ov, o_pc); end
      total++; if (o_rv !== 1'b1 || o_ra !== 32'h800) begin bad++; $display("FAIL fq_target k=%0d: got v=%b a=%h want v=1 a=00000800", k, o_rv, o_ra); end
    end
    step(1'b0, '0, 1'b0, 1'b1);
`ifdef IF_PERF_CNT_EN
    total++; if (o_flush - f0 !== 32'd1) begin bad++; $display("FAIL perf_flush: got delta %0d want 1", o_flush - f0); end
    total++; if (o_stall - s0 !== 32'd3) begin bad++; $display("FAIL perf_stall: got delta %0d want 3", o_stall - s0); end
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_latency();
    test_redirect_same_rsp();
    test_wrap();
    test_flush_queued();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Parametrised instruction-fetch front end; next generation of the single-PC fetch stage.
- Owns the fetch PC, issues in-order requests to instruction memory over a valid/ready channel, and accepts in-order responses.
- Buffers fetched {pc, instr} pairs in a QUEUE_DEPTH-entry prefetch queue feeding decode through a valid/ready handshake.
- Branch redirect flushes the queue and discards stale in-flight responses.

Parameters:
- ADDR_W, 32, PC/address width.
- DATA_W, 32, instruction width.
- RESET_PC, 0, fetch PC after reset.
- PC_STEP, 4, PC increment per fetch.
- QUEUE_DEPTH, 4, prefetch queue entries; also the maximum number of outstanding requests; power of two, >=2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- redirect  in  1  branch taken; load redirect_pc, flush.
- redirect_pc  in  ADDR_W  branch target.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  ADDR_W  request address (= fetch PC).
- imem_rsp_valid  in  1  response valid; in order; no backpressure.
- imem_rsp_data  in  DATA_W  fetched instruction.
- out_valid  out  1  queue head valid.
- out_ready  in  1  decode consumes head.
- out_pc  out  ADDR_W  PC of head instruction.
- out_pc_next  out  ADDR_W  out_pc + PC_STEP, modulo 2^ADDR_W.
- out_instr  out  DATA_W  head instruction.

Behaviour:
- Reset (rst=0, async): fetch_pc=RESET_PC; queue count=0; inflight=0; discard=0. Outputs: imem_req_valid=0, out_valid=0, imem_req_addr=RESET_PC, out_pc/out_pc_next/out_instr=0.
- Credit: imem_req_valid = (count + inflight < QUEUE_DEPTH) & !redirect.
- imem_req_addr = fetch_pc.
  - Addr and valid stay stable while valid & !ready, unless redirect.
- Request accept (valid & ready): fetch_pc += PC_STEP, wrapping modulo 2^ADDR_W; inflight += 1.
- Response, discard==0: {pc, data} written to queue tail; inflight -= 1.
  - The stored pc comes from an internal in-order pc tag FIFO of depth QUEUE_DEPTH.
- Response, discard>0: dropped; discard -= 1; inflight -= 1.
- Queue is registered with no bypass.
  - Response at edge N makes out_valid=1 from cycle N+1.
  - Minimum latency request-accept to out_valid: memory latency + 1.
- Pop: out_valid & out_ready. Push and pop in the same cycle are allowed at any count. The credit rule guarantees push never overflows.
- Head outputs hold when out_valid & !out_ready.
- Redirect (priority over everything):
  - In that cycle imem_req_valid=0 and out_valid is gated to 0 (combinational); no pop occurs.
  - At the edge: fetch_pc <= redirect_pc; queue cleared; pc tag FIFO cleared.
  - discard <= inflight - imem_rsp_valid; a same-cycle response is dropped.
  - inflight <= inflight - imem_rsp_valid.
  - The next cycle issues a request to redirect_pc if credit allows.
- Redirect while discard>0: the new discard value replaces the old one per the same formula, so no stale response ever leaks.
- Back-to-back redirects: the last one wins.
- Redirect during reset is ignored.
- Misaligned redirect_pc is not checked; it is used as given.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- Defined: adds ports perf_stall_cnt (out, 32) and perf_flush_cnt (out, 32), both reset to 0, saturating at 2^32-1.
  - perf_stall_cnt increments each cycle out_valid=0 with no redirect.
  - perf_flush_cnt increments each redirect cycle that drops at least one queued or in-flight instruction.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release with RESET_PC=0x100, memory ready=1, 1-cycle latency, out_ready=1 -> addrs 0x100,0x104,0x108... issued one per cycle; out_pc follows 2 cycles behind with matching out_pc_next; no gaps.
- out_ready=0 held, memory 1-cycle -> exactly 4 requests (0x0..0xC) issued, then imem_req_valid=0; out_pc holds 0x0; on out_ready=1, 0x0..0xC drain in order and requests resume at 0x10.
- Memory latency 3, 3 requests in flight, redirect to 0x2000 -> next request addr 0x2000; the 3 stale responses are dropped; first out_pc=0x2000.
- Redirect in the same cycle as a response with inflight=2 -> discard=1; both old responses dropped; queue empty; out_valid=0 in the redirect cycle.
- ADDR_W=32, redirect to 0xFFFFFFF8 -> fetch sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; out_pc_next of 0xFFFFFFFC = 0x0.
- IF_PERF_CNT_EN, redirect with 2 queued entries, then 3 empty cycles -> perf_flush_cnt=1, perf_stall_cnt=3 after the refill delay.
